// File: rtl/pause_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pause_ctrl_pkg
// Description : Shared types and constants for the pause/dim controller.
//               Holds the pause FSM state encoding, the RGB field widths of
//               the 8-bit {r[2:0],g[2:0],b[1:0]} pixel and the default
//               dimming delay.
// Config      : PAUSE_CTRL_FRAME_ALIGN_EN (PEND_* states used only when set)
// Revision    : 1.0 - initial release
// ============================================================================
package pause_ctrl_pkg;

  // PEND_* states are only reachable in the frame-aligned build.
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_PEND_ON  = 2'b01,
    ST_PAUSED   = 2'b10,
    ST_PEND_OFF = 2'b11
  } state_t;

  localparam int R_W   = 3;
  localparam int G_W   = 3;
  localparam int B_W   = 2;
  localparam int RGB_W = R_W + G_W + B_W;

  // 10 s of user pause at 48 MHz before the picture dims.
  localparam logic [31:0] DIM_CYCLES_DEFAULT = 32'h1C9C3800;

endpackage : pause_ctrl_pkg
`default_nettype wire

// File: rtl/pause_ctrl_rgb_dimmer.sv
`default_nettype none
// ============================================================================
// Module      : pause_ctrl_rgb_dimmer
// Description : Splits the 8-bit pixel into its R/G/B fields, halves each
//               field when i_en is set, and registers the result through an
//               RGB_LAT-deep pipeline. i_en travels down a matching pipeline
//               so o_en describes the pixel currently on o_rgb.
// Ports       : clk_sys  - system clock
//               reset    - synchronous, active-high
//               i_en     - apply dimming to this pixel
//               i_rgb    - {r[2:0],g[2:0],b[1:0]} pixel in
//               o_rgb    - pixel out, RGB_LAT cycles later
//               o_en     - i_en delayed to match o_rgb
// Config      : none (behaviour identical with/without
//               PAUSE_CTRL_FRAME_ALIGN_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module pause_ctrl_rgb_dimmer
  import pause_ctrl_pkg::*;
#(
  parameter int RGB_LAT = 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             i_en,
  input  logic [RGB_W-1:0] i_rgb,
  output logic [RGB_W-1:0] o_rgb,
  output logic             o_en
);

  logic [R_W-1:0]   w_r;
  logic [G_W-1:0]   w_g;
  logic [B_W-1:0]   w_b;
  logic [RGB_W-1:0] w_rgb_dim;
  logic [RGB_W-1:0] w_rgb_sel;

  logic [RGB_W-1:0] r_rgb_pipe [RGB_LAT];
  logic             r_en_pipe  [RGB_LAT];

  assign w_r = i_rgb[RGB_W-1 -: R_W];
  assign w_g = i_rgb[B_W +: G_W];
  assign w_b = i_rgb[0 +: B_W];

  // Each field shifted right by one: roughly half brightness per channel.
  assign w_rgb_dim = {1'b0, w_r[R_W-1:1], 1'b0, w_g[G_W-1:1], 1'b0, w_b[B_W-1:1]};
  assign w_rgb_sel = i_en ? w_rgb_dim : i_rgb;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < RGB_LAT; i++) begin
        r_rgb_pipe[i] <= '0;
        r_en_pipe[i]  <= 1'b0;
      end
    end else begin
      r_rgb_pipe[0] <= w_rgb_sel;
      r_en_pipe[0]  <= i_en;
      for (int i = 1; i < RGB_LAT; i++) begin
        r_rgb_pipe[i] <= r_rgb_pipe[i-1];
        r_en_pipe[i]  <= r_en_pipe[i-1];
      end
    end
  end

  assign o_rgb = r_rgb_pipe[RGB_LAT-1];
  assign o_en  = r_en_pipe[RGB_LAT-1];

endmodule : pause_ctrl_rgb_dimmer
`default_nettype wire

// File: rtl/pause_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pause_ctrl
// Description : Central pause/dim controller. Merges the user pause toggle,
//               OSD-open pause and hiscore RAM access into the core's
//               active-low pause_n, aligns user/OSD pause entry and exit to
//               the start of vertical blank, and dims the picture after a
//               long user pause.
// Ports       : clk_sys      - system clock (48 MHz)
//               reset        - synchronous, active-high
//               pause_btn    - raw joystick pause button level
//               osd_open     - OSD visible
//               osd_pause_en - pause while the OSD is open
//               hs_access    - hiscore module requests core RAM
//               vblank       - vertical blank from video timing
//               rgb_in       - {r[2:0],g[2:0],b[1:0]} pixel in
//               pause_n      - to core, 0 = halted
//               paused       - user/OSD pause in effect
//               dim_active   - dimming applied to rgb_out
//               rgb_out      - pixel out, RGB_LAT cycles after rgb_in
// Config      : PAUSE_CTRL_FRAME_ALIGN_EN - when defined, pause entry and
//               exit wait for the rising edge of vblank (PEND_* states);
//               when undefined, RUN<->PAUSED follows the request directly.
// Revision    : 1.0 - initial release
// ============================================================================
module pause_ctrl
  import pause_ctrl_pkg::*;
#(
  parameter logic [31:0] DIM_CYCLES = DIM_CYCLES_DEFAULT,
  parameter int          RGB_LAT    = 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             pause_btn,
  input  logic             osd_open,
  input  logic             osd_pause_en,
  input  logic             hs_access,
  input  logic             vblank,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             pause_n,
  output logic             paused,
  output logic             dim_active,
  output logic [RGB_W-1:0] rgb_out
);

  logic        r_btn_d;
  logic        r_toggle;
  state_t      r_state;
  logic        r_paused;
  logic        r_pause_n;
  logic [31:0] r_dim_cnt;

  logic        w_btn_rise;
  logic        w_want;
  state_t      w_state_nxt;
  logic        w_paused_nxt;
  logic        w_dim_en;

  assign w_btn_rise = pause_btn & ~r_btn_d;
  assign w_want     = r_toggle | (osd_open & osd_pause_en);

`ifdef PAUSE_CTRL_FRAME_ALIGN_EN
  logic r_vblank_d;
  logic w_vbl_rise;

  always_ff @(posedge clk_sys) begin
    if (reset) r_vblank_d <= 1'b0;
    else       r_vblank_d <= vblank;
  end

  assign w_vbl_rise = vblank & ~r_vblank_d;

  // A request arriving together with vbl_rise still passes through PEND_*,
  // so the transition lands on the following frame boundary.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:      if (w_want) w_state_nxt = ST_PEND_ON;
      ST_PEND_ON:  if (!w_want) w_state_nxt = ST_RUN;
                   else if (w_vbl_rise) w_state_nxt = ST_PAUSED;
      ST_PAUSED:   if (!w_want) w_state_nxt = ST_PEND_OFF;
      ST_PEND_OFF: if (w_want) w_state_nxt = ST_PAUSED;
                   else if (w_vbl_rise) w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_RUN;
    endcase
  end
`else
  // Frame alignment disabled: vblank has no influence on pausing.
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (w_want) w_state_nxt = ST_PAUSED;
      ST_PAUSED: if (!w_want) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end
`endif

  // PEND_OFF still counts as paused: the core keeps halted until the frame edge.
  assign w_paused_nxt = (w_state_nxt == ST_PAUSED) || (w_state_nxt == ST_PEND_OFF);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Previous level resets high so a button held through reset is not an edge.
      r_btn_d   <= 1'b1;
      r_toggle  <= 1'b0;
      r_state   <= ST_RUN;
      r_paused  <= 1'b0;
      r_pause_n <= 1'b1;
      r_dim_cnt <= '0;
    end else begin
      r_btn_d   <= pause_btn;
      r_toggle  <= r_toggle ^ w_btn_rise;
      r_state   <= w_state_nxt;
      r_paused  <= w_paused_nxt;
      // hs_access bypasses the frame alignment entirely.
      r_pause_n <= ~(w_paused_nxt | hs_access);
      // Only a user pause (toggle set) ages towards dimming; OSD pause does not.
      if ((r_state == ST_PAUSED) && r_toggle) begin
        if (r_dim_cnt != DIM_CYCLES) r_dim_cnt <= r_dim_cnt + 32'd1;
      end else begin
        r_dim_cnt <= '0;
      end
    end
  end

  assign w_dim_en = (r_dim_cnt == DIM_CYCLES);

  pause_ctrl_rgb_dimmer #(
    .RGB_LAT (RGB_LAT)
  ) u_rgb_dimmer (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_en    (w_dim_en),
    .i_rgb   (rgb_in),
    .o_rgb   (rgb_out),
    .o_en    (dim_active)
  );

  assign pause_n = r_pause_n;
  assign paused  = r_paused;

endmodule : pause_ctrl
`default_nettype wire

// File: tb/tb_pause_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pause_ctrl
// Description : Self-checking bench for pause_ctrl. A cycle model computes
//               the expected outputs at every clock edge and pushes them to
//               a queue; the falling-edge checker pops and compares them with
//               the DUT. A few directed checks cover the headline scenarios.
// Config      : follows PAUSE_CTRL_FRAME_ALIGN_EN like the design
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pause_ctrl;
  import pause_ctrl_pkg::*;

  localparam logic [31:0] DIM = 32'd100;
  localparam int          LAT = 1;

  logic       clk_sys      = 1'b0;
  logic       reset        = 1'b1;
  logic       pause_btn    = 1'b0;
  logic       osd_open     = 1'b0;
  logic       osd_pause_en = 1'b0;
  logic       hs_access    = 1'b0;
  logic       vblank       = 1'b0;
  logic [7:0] rgb_in       = 8'h00;
  logic       pause_n;
  logic       paused;
  logic       dim_active;
  logic [7:0] rgb_out;

  always #5 clk_sys = ~clk_sys;

  pause_ctrl #(
    .DIM_CYCLES (DIM),
    .RGB_LAT    (LAT)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .pause_btn    (pause_btn),
    .osd_open     (osd_open),
    .osd_pause_en (osd_pause_en),
    .hs_access    (hs_access),
    .vblank       (vblank),
    .rgb_in       (rgb_in),
    .pause_n      (pause_n),
    .paused       (paused),
    .dim_active   (dim_active),
    .rgb_out      (rgb_out)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";
  bit    rgb_rand = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // States: 0 RUN, 1 PEND_ON, 2 PAUSED, 3 PEND_OFF
  int          m_state  = 0;
  logic        m_btn_d  = 1'b1;
  logic        m_toggle = 1'b0;
  logic        m_vbl_d  = 1'b0;
  logic        m_paused = 1'b0;
  logic        m_pausen = 1'b1;
  logic [31:0] m_cnt    = '0;
  logic [8:0]  m_pipe [LAT];
  logic [10:0] exp_q [$];

  always @(posedge clk_sys) begin : p_model
    logic       want;
    logic       vrise;
    logic       dim_now;
    logic [7:0] shown;
    int         ns;
    if (reset) begin
      m_state  = 0;
      m_btn_d  = 1'b1;
      m_toggle = 1'b0;
      m_vbl_d  = 1'b0;
      m_paused = 1'b0;
      m_pausen = 1'b1;
      m_cnt    = '0;
      for (int i = 0; i < LAT; i++) m_pipe[i] = '0;
    end else begin
      want    = m_toggle | (osd_open & osd_pause_en);
      vrise   = vblank & ~m_vbl_d;
      dim_now = (m_cnt == DIM);
      ns      = m_state;
`ifdef PAUSE_CTRL_FRAME_ALIGN_EN
      if      (m_state == 0 && want)           ns = 1;
      else if (m_state == 1 && !want)          ns = 0;
      else if (m_state == 1 && vrise)          ns = 2;
      else if (m_state == 2 && !want)          ns = 3;
      else if (m_state == 3 && want)           ns = 2;
      else if (m_state == 3 && vrise)          ns = 0;
`else
      if      (m_state == 0 && want)  ns = 2;
      else if (m_state == 2 && !want) ns = 0;
`endif
      shown = dim_now ? {1'b0, rgb_in[7:6], 1'b0, rgb_in[4:3], 1'b0, rgb_in[1]} : rgb_in;
      for (int i = LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = {dim_now, shown};
      if (m_state == 2 && m_toggle) m_cnt = (m_cnt == DIM) ? m_cnt : m_cnt + 32'd1;
      else                          m_cnt = '0;
      m_paused = (ns == 2) || (ns == 3);
      m_pausen = ~(m_paused | hs_access);
      m_toggle = m_toggle ^ (pause_btn & ~m_btn_d);
      m_btn_d  = pause_btn;
      m_vbl_d  = vblank;
      m_state  = ns;
    end
    exp_q.push_back({m_pausen, m_paused, m_pipe[LAT-1]});
  end

  // ---------------- scoreboard checker ----------------
  always @(negedge clk_sys) begin : p_check
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({phase, "/out{pn,p,dim,rgb}"},
               {21'd0, pause_n, paused, dim_active, rgb_out}, {21'd0, e});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
      if (rgb_rand) rgb_in = 8'($urandom);
    end
  endtask

  task automatic vbl_pulse();
    vblank = 1'b1;
    tick(4);
    vblank = 1'b0;
    tick(3);
  endtask

  task automatic press();
    pause_btn = 1'b1;
    tick(2);
    pause_btn = 1'b0;
    tick(1);
  endtask

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    int lows;
    tick(3);
    reset = 1'b0;
    tick(2);

    // 1: button mid-frame, vblank 500 cycles later
    phase = "t1_btn_pause";
    press();
    tick(500);
    vbl_pulse();

    // 2: long user pause dims; second press undims
    phase = "t2_dim";
    tick(120);
    rgb_rand = 1'b0;
    rgb_in   = 8'hFF;
    tick(3);
    check_eq("t2_rgb_dimmed", {24'd0, rgb_out}, 32'h6D);
    check_eq("t2_dim_active", {31'd0, dim_active}, 32'd1);
    check_eq("t2_pause_n_low", {31'd0, pause_n}, 32'd0);
    press();
    tick(3);
    check_eq("t2_rgb_undimmed", {24'd0, rgb_out}, 32'hFF);
    check_eq("t2_dim_cleared", {31'd0, dim_active}, 32'd0);
    rgb_rand = 1'b1;
    vbl_pulse();
    tick(5);

    // 3: hiscore access while running
    phase = "t3_hs";
    check_eq("t3_start_running", {31'd0, pause_n}, 32'd1);
    hs_access = 1'b1;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_sys);
      #1;
      if (i == 19) hs_access = 1'b0;
      @(negedge clk_sys);
      if (!pause_n) lows++;
      if (i == 10) check_eq("t3_paused_stays_0", {31'd0, paused}, 32'd0);
    end
    check_eq("t3_low_cycles", lows, 32'd20);

    // 4: OSD pause only when enabled, never dims
    phase = "t4_osd";
    osd_open = 1'b1;
    tick(20);
    vbl_pulse();
    check_eq("t4_no_pause_disabled", {31'd0, paused}, 32'd0);
    osd_pause_en = 1'b1;
    tick(30);
    vbl_pulse();
    tick(150);
    check_eq("t4_osd_paused", {31'd0, paused}, 32'd1);
    check_eq("t4_osd_no_dim", {31'd0, dim_active}, 32'd0);
    osd_open = 1'b0;
    tick(10);
    vbl_pulse();
    osd_pause_en = 1'b0;
    tick(5);

    // 5: press and cancel before vblank
    phase = "t5_cancel";
    press();
    tick(4);
    press();
    tick(40);
    vbl_pulse();
    tick(5);
    check_eq("t5_running", {31'd0, pause_n}, 32'd1);

    // 6: reset while paused, dimmed and button held
    phase = "t6_reset";
    pause_btn = 1'b1;
    tick(10);
    vbl_pulse();
    tick(115);
    check_eq("t6_dimmed_before_reset", {31'd0, dim_active}, 32'd1);
    reset = 1'b1;
    tick(2);
    @(negedge clk_sys);
    check_eq("t6_reset_outputs", {21'd0, pause_n, paused, dim_active, rgb_out}, 32'h400);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    tick(20);
    vbl_pulse();
    tick(5);
    check_eq("t6_held_no_toggle", {31'd0, paused}, 32'd0);
    pause_btn = 1'b0;
    tick(5);
    press();
    tick(10);
    vbl_pulse();
    tick(5);
    check_eq("t6_repress_paused", {31'd0, paused}, 32'd1);
    tick(5);

    @(negedge clk_sys);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pause_ctrl
`default_nettype wire
